// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register address
// width, controller state encodings, stage-control bundle and the NOP word
// the datapath loads into a flushed pipeline register.
package pipe_hazard_ctrl_pkg;

   localparam int REG_ADDR_WIDTH = 5;

   // Canonical RV32I NOP (addi x0, x0, 0) loaded by a flushed register.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // Controller states; codes 2 and 3 are illegal and fall back to RUN.
   typedef enum logic [1:0] {
      PCTRL_RUN      = 2'd0,
      PCTRL_MEM_WAIT = 2'd1
   } pctrl_state_e;

   // Enables and flushes for the PC and the four pipeline registers.
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_flush;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard inputs from the datapath and the
// enable/flush controls going back to every pipeline register.
// master = the controller, slave = the datapath side.
interface pipe_hazard_ctrl_if
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH
) ();

   logic [REG_ADDR_WIDTH-1:0] id_rs1;
   logic [REG_ADDR_WIDTH-1:0] id_rs2;
   logic                      id_uses_rs1;
   logic                      id_uses_rs2;
   logic [REG_ADDR_WIDTH-1:0] ex_rd;
   logic                      ex_mem_read;
   logic                      ex_branch_taken;
   logic                      mem_req;
   logic                      mem_ack;

   logic                      pc_en;
   logic                      if_id_en;
   logic                      id_ex_en;
   logic                      ex_mem_en;
   logic                      mem_wb_en;
   logic                      if_id_flush;
   logic                      id_ex_flush;
   logic                      mem_wb_flush;
   logic                      mem_timeout;
   pctrl_state_e              ctrl_state;

   modport master (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_req, mem_ack,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, ctrl_state
   );

   modport slave (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_req, mem_ack,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, ctrl_state
   );

endinterface

// File: rtl/pipe_ctrl_wait_timer.sv
// Data-memory wait counter. start loads 1 (first frozen cycle), inc counts
// further frozen cycles, clear returns to 0. expire flags the last cycle
// the controller may keep waiting before it aborts the access.
module pipe_ctrl_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic inc,
   input  logic clear,
   output logic expire
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Next count: clear beats start, start beats increment.
   always_comb begin
      // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (start) begin
         cnt_d = CNT_WIDTH'(1);
      end else if (inc) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Counter register; reset clears it immediately, even mid-wait.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments so every flop samples values from before the edge.
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == CNT_WIDTH'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: drives PC enable and the
// enable/flush of IF/ID, ID/EX, EX/MEM, MEM/WB. Resolves, highest priority
// first: data-memory wait (with timeout abort), taken branch, load-use.
// Stage controls are combinational for a same-cycle response; only the
// state and the wait counter are registered.
// Optional: define PIPE_CTRL_PERF_EN for saturating performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH,
   parameter int MEM_TIMEOUT    = 16,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pipe_hazard_ctrl_if.master    bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_flushes,
   output logic [15:0]           perf_timeouts
`endif
);

   pctrl_state_e              state_q, state_d;
   logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
   logic                      mem_stall, load_use, timeout, freeze, legal;
   logic                      cnt_start, cnt_inc, cnt_clear, cnt_expire;
   stage_ctrl_t               ctrl;
   logic                      mem_timeout_c;

   assign rs1 = bus.id_rs1;
   assign rs2 = bus.id_rs2;
   assign rd  = bus.ex_rd;

   // Hazard decode: memory stall, load-use match, timeout and freeze.
   always_comb begin
      legal     = (state_q == PCTRL_RUN) || (state_q == PCTRL_MEM_WAIT);
      mem_stall = bus.mem_req & ~bus.mem_ack;
      load_use  = bus.ex_mem_read && (rd != '0) &&
                  ((bus.id_uses_rs1 && (rs1 == rd)) ||
                   (bus.id_uses_rs2 && (rs2 == rd)));
      timeout   = (state_q == PCTRL_MEM_WAIT) && mem_stall && cnt_expire;
      freeze    = legal && mem_stall && !timeout;
   end

   // Next state and counter commands; anything but a continued stall returns to RUN.
   always_comb begin
      state_d   = PCTRL_RUN;
      cnt_start = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clear = 1'b1;
      case (state_q)
         PCTRL_RUN: begin
            if (freeze) begin
               state_d   = PCTRL_MEM_WAIT;
               cnt_start = 1'b1;
               cnt_clear = 1'b0;
            end
         end
         PCTRL_MEM_WAIT: begin
            if (freeze) begin
               state_d   = PCTRL_MEM_WAIT;
               cnt_inc   = 1'b1;
               cnt_clear = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PCTRL_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_ctrl_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_wait_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (cnt_start),
      .inc     (cnt_inc),
      .clear   (cnt_clear),
      .expire  (cnt_expire)
   );

   // Stage-control mux in priority order; everything is forced low during reset.
   always_comb begin
      ctrl          = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                        ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0};
      mem_timeout_c = 1'b0;
      if (freeze) begin
         // Upstream frozen; WB takes a bubble so the load is not written twice.
         ctrl.pc_en        = 1'b0;
         ctrl.if_id_en     = 1'b0;
         ctrl.id_ex_en     = 1'b0;
         ctrl.ex_mem_en    = 1'b0;
         ctrl.mem_wb_flush = 1'b1;
      end else if (bus.ex_branch_taken) begin
         // Load the target and squash the two younger instructions.
         ctrl.if_id_flush  = 1'b1;
         ctrl.id_ex_flush  = 1'b1;
      end else if (load_use) begin
         // Hold IF/ID one cycle and send a bubble into EX.
         ctrl.pc_en        = 1'b0;
         ctrl.if_id_en     = 1'b0;
         ctrl.id_ex_flush  = 1'b1;
      end
      if (timeout) begin
         // Aborted access: drop whatever the load would have written back.
         ctrl.mem_wb_flush = 1'b1;
         mem_timeout_c     = 1'b1;
      end
      if (!reset_n) begin
         ctrl          = '0;
         mem_timeout_c = 1'b0;
      end
   end

   assign bus.pc_en        = ctrl.pc_en;
   assign bus.if_id_en     = ctrl.if_id_en;
   assign bus.id_ex_en     = ctrl.id_ex_en;
   assign bus.ex_mem_en    = ctrl.ex_mem_en;
   assign bus.mem_wb_en    = ctrl.mem_wb_en;
   assign bus.if_id_flush  = ctrl.if_id_flush;
   assign bus.id_ex_flush  = ctrl.id_ex_flush;
   assign bus.mem_wb_flush = ctrl.mem_wb_flush;
   assign bus.mem_timeout  = mem_timeout_c;
   assign bus.ctrl_state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
   logic [31:0] perf_flushes_q, perf_flushes_d;
   logic [15:0] perf_timeouts_q, perf_timeouts_d;

   // Saturating event counters: stalled PC cycles, branch flushes, timeouts.
   always_comb begin
      perf_stall_cycles_d = perf_stall_cycles_q;
      perf_flushes_d      = perf_flushes_q;
      perf_timeouts_d     = perf_timeouts_q;
      if (!ctrl.pc_en && (perf_stall_cycles_q != '1)) begin
         perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
      end
      if (ctrl.if_id_flush && (perf_flushes_q != '1)) begin
         perf_flushes_d = perf_flushes_q + 32'd1;
      end
      if (mem_timeout_c && (perf_timeouts_q != '1)) begin
         perf_timeouts_d = perf_timeouts_q + 16'd1;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cycles_q <= '0;
         perf_flushes_q      <= '0;
         perf_timeouts_q     <= '0;
      end else begin
         perf_stall_cycles_q <= perf_stall_cycles_d;
         perf_flushes_q      <= perf_flushes_d;
         perf_timeouts_q     <= perf_timeouts_d;
      end
   end

   assign perf_stall_cycles = perf_stall_cycles_q;
   assign perf_flushes      = perf_flushes_q;
   assign perf_timeouts     = perf_timeouts_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): reset checks,
// a table of single-cycle hazard vectors, hand-written multi-cycle
// sequences (memory wait, request drop, timeout, reset mid-wait) and a
// randomized phase checked against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int TMO = 4;

   // Expected stage controls {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,mem_wb flush}.
   localparam logic [7:0] C_RUN = 8'b11111_000;
   localparam logic [7:0] C_LU  = 8'b00111_010;
   localparam logic [7:0] C_BR  = 8'b11111_110;
   localparam logic [7:0] C_FRZ = 8'b00001_001;
   localparam logic [7:0] C_TMO = 8'b11111_001;

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       mread, br, req, ack;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [7:0]  ctrl;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: consecutive frozen cycles of the current access, event counts.
   int   m_waited = 0;
   int   m_stall  = 0;
   int   m_flush  = 0;
   int   m_tmo    = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flushes;
   logic [15:0] perf_timeouts;
`endif

   pipe_hazard_ctrl #(
      .REG_ADDR_WIDTH (5),
      .MEM_TIMEOUT    (TMO),
      .CNT_WIDTH      (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushes      (perf_flushes),
      .perf_timeouts     (perf_timeouts)
`endif
   );

   function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                input int rd, input bit mread, input bit br,
                                input bit req, input bit ack);
      stim_t s;
      s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = u1; s.u2 = u2; s.rd = 5'(rd);
      s.mread = mread; s.br = br; s.req = req; s.ack = ack;
      return s;
   endfunction

   function automatic vec_t mkv(input stim_t s, input logic [7:0] c, input string n);
      vec_t v;
      v.s = s; v.ctrl = c; v.name = n;
      return v;
   endfunction

   function automatic logic [10:0] e(input logic [7:0] c, input logic to, input logic [1:0] st);
      return {c, to, st};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
              bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush,
              bus.mem_timeout, 2'(bus.ctrl_state)};
   endfunction

   // Expected outputs from the hazard rules and the number of cycles already waited.
   function automatic logic [10:0] model_exp(input stim_t s);
      bit stalled, to, frz, lu;
      logic [7:0] c;
      stalled = s.req && !s.ack;
      to      = stalled && (m_waited == TMO - 1);
      frz     = stalled && !to;
      lu      = s.mread && (s.rd != 0) &&
                ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      c = frz ? C_FRZ : s.br ? C_BR : lu ? C_LU : C_RUN;
      if (to) c[0] = 1'b1;
      return {c, to, (m_waited > 0) ? 2'd1 : 2'd0};
   endfunction

   task automatic model_adv(input stim_t s);
      bit stalled, to, frz;
      logic [10:0] x;
      x       = model_exp(s);
      stalled = s.req && !s.ack;
      to      = stalled && (m_waited == TMO - 1);
      frz     = stalled && !to;
      if (!x[10]) m_stall++;
      if (s.br && !frz) m_flush++;
      if (to) m_tmo++;
      m_waited = frz ? m_waited + 1 : 0;
   endtask

   task automatic model_reset();
      m_waited = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input stim_t s);
      bus.id_rs1          = s.rs1;
      bus.id_rs2          = s.rs2;
      bus.id_uses_rs1     = s.u1;
      bus.id_uses_rs2     = s.u2;
      bus.ex_rd           = s.rd;
      bus.ex_mem_read     = s.mread;
      bus.ex_branch_taken = s.br;
      bus.mem_req         = s.req;
      bus.mem_ack         = s.ack;
   endtask

   // One cycle: drive after the falling edge, check, then let the rising edge commit.
   task automatic step(input stim_t s, input logic [10:0] exp, input string name);
      @(negedge clk);
      drive(s);
      #1;
      check(name, 32'(dut_vec()), 32'(exp));
      model_adv(s);
   endtask

   stim_t idle, s_req, s_wait_br, rs;
   vec_t  tbl[11];

   initial begin
      idle      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      s_req     = mk(1, 2, 1, 1, 3, 0, 0, 1, 0);
      s_wait_br = mk(1, 5, 1, 1, 5, 1, 1, 1, 0);

      tbl[0]  = mkv(mk(1, 2, 1, 1, 3, 1, 0, 0, 0),   C_RUN, "no_hazard");
      tbl[1]  = mkv(mk(7, 5, 1, 1, 5, 1, 0, 0, 0),   C_LU,  "lu_rs2_x5");
      tbl[2]  = mkv(mk(7, 5, 1, 1, 0, 0, 0, 0, 0),   C_RUN, "lu_cleared_next");
      tbl[3]  = mkv(mk(0, 0, 1, 1, 0, 1, 0, 0, 0),   C_RUN, "x0_no_stall");
      tbl[4]  = mkv(mk(9, 1, 0, 1, 9, 1, 0, 0, 0),   C_RUN, "rs1_unused");
      tbl[5]  = mkv(mk(9, 1, 1, 1, 9, 0, 0, 0, 0),   C_RUN, "not_load");
      tbl[6]  = mkv(mk(31, 0, 1, 0, 31, 1, 0, 0, 0), C_LU,  "lu_rs1_x31");
      tbl[7]  = mkv(mk(5, 5, 1, 1, 5, 1, 1, 0, 0),   C_BR,  "branch_over_lu");
      tbl[8]  = mkv(mk(1, 2, 1, 1, 3, 0, 1, 0, 0),   C_BR,  "branch_only");
      tbl[9]  = mkv(mk(4, 6, 0, 1, 6, 1, 0, 1, 1),   C_LU,  "req_acked_lu");
      tbl[10] = mkv(mk(1, 2, 1, 1, 3, 0, 0, 0, 1),   C_RUN, "ack_without_req");

      // Reset: every output low even with hazards on the inputs.
      reset_n = 1'b0;
      drive(mk(1, 1, 1, 1, 1, 1, 1, 1, 0));
      #3;
      check("reset_outputs", 32'(dut_vec()), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(idle);
      reset_n = 1'b1;
      model_reset();

      // Single-cycle hazard vectors in RUN.
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].s, e(tbl[i].ctrl, 1'b0, 2'd0), tbl[i].name);
      end

      // Memory wait acked on the 4th cycle; branch/load-use held but ignored until release.
      step(s_wait_br, e(C_FRZ, 1'b0, 2'd0), "memwait_c1");
      step(s_wait_br, e(C_FRZ, 1'b0, 2'd1), "memwait_c2");
      step(s_wait_br, e(C_FRZ, 1'b0, 2'd1), "memwait_c3");
      step(mk(1, 5, 1, 1, 5, 1, 1, 1, 1), e(C_BR, 1'b0, 2'd1), "memwait_ack_branch");
      step(idle, e(C_RUN, 1'b0, 2'd0), "after_ack_run");

      // mem_req dropping in MEM_WAIT acts as ack; load-use applies that cycle.
      step(s_req, e(C_FRZ, 1'b0, 2'd0), "drop_c1");
      step(s_req, e(C_FRZ, 1'b0, 2'd1), "drop_c2");
      step(mk(3, 2, 1, 0, 3, 1, 0, 0, 0), e(C_LU, 1'b0, 2'd1), "req_drop_release_lu");
      step(idle, e(C_RUN, 1'b0, 2'd0), "after_drop_run");

      // Timeout at the 4th waited cycle, then a fresh wait on the retried request.
      step(s_req, e(C_FRZ, 1'b0, 2'd0), "tmo_c1");
      step(s_req, e(C_FRZ, 1'b0, 2'd1), "tmo_c2");
      step(s_req, e(C_FRZ, 1'b0, 2'd1), "tmo_c3");
      step(s_req, e(C_TMO, 1'b1, 2'd1), "timeout_pulse");
      step(s_req, e(C_FRZ, 1'b0, 2'd0), "rewait_c1");
      step(s_req, e(C_FRZ, 1'b0, 2'd1), "rewait_c2");

      // Reset mid-wait: outputs and state drop immediately, counter starts over.
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_async", 32'(dut_vec()), 32'd0);
      @(posedge clk);
      #1;
      check("reset_held", 32'(dut_vec()), 32'd0);
      @(negedge clk);
      drive(idle);
      reset_n = 1'b1;
      model_reset();
      step(idle,  e(C_RUN, 1'b0, 2'd0), "post_reset_run");
      step(s_req, e(C_FRZ, 1'b0, 2'd0), "post_reset_c1");
      step(s_req, e(C_FRZ, 1'b0, 2'd1), "post_reset_c2");
      step(s_req, e(C_FRZ, 1'b0, 2'd1), "post_reset_c3");
      step(s_req, e(C_TMO, 1'b1, 2'd1), "post_reset_timeout");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         rs.rs1   = 5'($urandom_range(0, 3));
         rs.rs2   = 5'($urandom_range(0, 3));
         rs.rd    = 5'($urandom_range(0, 3));
         rs.u1    = 1'($urandom_range(0, 1));
         rs.u2    = 1'($urandom_range(0, 1));
         rs.mread = 1'($urandom_range(0, 1));
         rs.br    = ($urandom_range(0, 5) == 0);
         rs.req   = (m_waited > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         rs.ack   = ($urandom_range(0, 3) == 0);
         step(rs, model_exp(rs), "random");
      end

`ifdef PIPE_CTRL_PERF_EN
      @(negedge clk);
      #1;
      check("perf_stall_cycles", perf_stall_cycles, 32'(m_stall));
      check("perf_flushes", perf_flushes, 32'(m_flush));
      check("perf_timeouts", 32'(perf_timeouts), 32'(m_tmo));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
